// File: rtl/mem_stage_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_access
// Description : MEM pipeline stage - data-memory req/ack access, branch
//               resolution and the registered MEM->WB bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_access #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_valid,
    input  logic [74:0] ex_mem_bundle,
    output logic        mem_stall,
    output logic        branch_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_err,
    output logic        mem_wb_valid,
    output logic [70:0] mem_wb_bundle
);

    localparam logic [0:0]       C_ST_IDLE  = 1'b0;
    localparam logic [0:0]       C_ST_WAIT  = 1'b1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_branch;
    logic        w_mem_read;
    logic        w_mem_write;
    logic [31:0] w_alu_result;
    logic        w_zero;
    logic [31:0] w_store_data;
    logic [4:0]  w_reg_dest;
    logic        w_memop;
    logic        w_aligned;
    logic        w_timeout_hit;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             wbv_q, wbv_d;
    logic [70:0]      wbb_q, wbb_d;

    assign w_reg_write  = ex_mem_bundle[74];
    assign w_mem_to_reg = ex_mem_bundle[73];
    assign w_branch     = ex_mem_bundle[72];
    assign w_mem_read   = ex_mem_bundle[71];
    assign w_mem_write  = ex_mem_bundle[70];
    assign w_alu_result = ex_mem_bundle[69:38];
    assign w_zero       = ex_mem_bundle[37];
    assign w_store_data = ex_mem_bundle[36:5];
    assign w_reg_dest   = ex_mem_bundle[4:0];

    assign w_memop       = w_mem_read | w_mem_write;
    assign w_aligned     = (w_alu_result[1:0] == 2'b00);
    assign w_timeout_hit = (cnt_q == C_CNT_LAST);

    // Stall is released in the completion cycle so upstream advances on the
    // same edge the result is registered; reset forces it low immediately.
    assign mem_stall = ~reset &
                       (((state_q == C_ST_IDLE) & ex_mem_valid & w_memop & w_aligned) |
                        ((state_q == C_ST_WAIT) & ~dmem_ack & ~w_timeout_hit));

    assign branch_taken = ex_mem_valid & w_branch & w_zero;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        wbv_d   = 1'b0;
        wbb_d   = wbb_q;
        case (state_q)
            C_ST_IDLE: begin
                if (ex_mem_valid) begin
                    if (!w_memop) begin
                        wbv_d = 1'b1;
                        wbb_d = {w_reg_write, w_mem_to_reg, 32'h0, w_alu_result, w_reg_dest};
                    end else if (!w_aligned) begin
                        err_d = 1'b1;
                        wbv_d = 1'b1;
                        wbb_d = {1'b0, w_mem_to_reg, 32'h0, w_alu_result, w_reg_dest};
                    end else begin
                        // A set mem_write wins when both read and write are flagged.
                        req_d   = 1'b1;
                        we_d    = w_mem_write;
                        addr_d  = w_alu_result;
                        wdata_d = w_store_data;
                        cnt_d   = '0;
                        state_d = C_ST_WAIT;
                    end
                end
            end
            C_ST_WAIT: begin
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    wbv_d   = 1'b1;
                    wbb_d   = {w_reg_write, w_mem_to_reg, (we_q ? 32'h0 : dmem_rdata),
                               addr_q, w_reg_dest};
                    state_d = C_ST_IDLE;
                end else if (w_timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    wbv_d   = 1'b1;
                    wbb_d   = {1'b0, w_mem_to_reg, 32'h0, addr_q, w_reg_dest};
                    state_d = C_ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wbv_q   <= 1'b0;
            wbb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wbv_q   <= wbv_d;
            wbb_q   <= wbb_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_err       = err_q;
    assign mem_wb_valid  = wbv_q;
    assign mem_wb_bundle = wbb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_access
// Description : Self-checking bench for mem_stage_access against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage_access;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_mem_valid;
    logic [74:0] ex_mem_bundle;
    logic        mem_stall;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_err;
    logic        mem_wb_valid;
    logic [70:0] mem_wb_bundle;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic err_m    = 1'b0;

    always #5 clk = ~clk;

    mem_stage_access #(.ACK_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_mem_valid (ex_mem_valid),
        .ex_mem_bundle(ex_mem_bundle),
        .mem_stall    (mem_stall),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .mem_err      (mem_err),
        .mem_wb_valid (mem_wb_valid),
        .mem_wb_bundle(mem_wb_bundle)
    );

    function automatic logic [74:0] mk(input logic rw, input logic m2r, input logic br,
                                       input logic mr, input logic mw, input logic [31:0] alu,
                                       input logic z, input logic [31:0] sd, input logic [4:0] rd);
        return {rw, m2r, br, mr, mw, alu, z, sd, rd};
    endfunction

    // Transaction-level expectation: ack_k is the WAIT cycle (1-based) carrying the ack.
    task automatic model(input logic [74:0] b, input int ack_k, input logic [31:0] rdv,
                         output int lat, output int reqc, output int stallc,
                         output logic [70:0] ob, output logic err_set);
        logic        memop;
        logic        store;
        logic [31:0] alu;
        memop   = b[71] | b[70];
        store   = b[70];
        alu     = b[69:38];
        err_set = 1'b0;
        if (!memop) begin
            lat = 1; reqc = 0; stallc = 0;
            ob  = {b[74], b[73], 32'h0, alu, b[4:0]};
        end else if (alu % 4 != 0) begin
            lat = 1; reqc = 0; stallc = 0; err_set = 1'b1;
            ob  = {1'b0, b[73], 32'h0, alu, b[4:0]};
        end else if (ack_k <= TO) begin
            lat = ack_k + 1; reqc = ack_k; stallc = ack_k;
            ob  = {b[74], b[73], (store ? 32'h0 : rdv), alu, b[4:0]};
        end else begin
            lat = TO + 1; reqc = TO; stallc = TO; err_set = 1'b1;
            ob  = {1'b0, b[73], 32'h0, alu, b[4:0]};
        end
    endtask

    // Drives one instruction (entered at posedge+1) and records what the DUT did.
    task automatic run_op(input logic [74:0] b, input int ack_k, input logic [31:0] rdv,
                          output int lat, output int reqc, output int stallc,
                          output logic [70:0] ob, output logic we_s, output logic [31:0] addr_s,
                          output logic [31:0] wdata_s, output logic held);
        lat = -1; reqc = 0; stallc = 0; ob = '0;
        we_s = 1'b0; addr_s = '0; wdata_s = '0; held = 1'b1;
        ex_mem_valid  = 1'b1;
        ex_mem_bundle = b;
        for (int cyc = 0; cyc < 40 && lat < 0; cyc++) begin
            dmem_ack   = (cyc == ack_k);
            dmem_rdata = (cyc == ack_k) ? rdv : $urandom;
            #3;
            if (mem_stall) stallc++;
            if (dmem_req) begin
                if (reqc == 0) begin
                    we_s = dmem_we; addr_s = dmem_addr; wdata_s = dmem_wdata;
                end else if (dmem_we !== we_s || dmem_addr !== addr_s || dmem_wdata !== wdata_s) begin
                    held = 1'b0;
                end
                reqc++;
            end
            @(posedge clk); #1;
            if (mem_wb_valid) begin
                lat = cyc + 1;
                ob  = mem_wb_bundle;
            end
        end
        ex_mem_valid = 1'b0;
        dmem_ack     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        err_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_mem_valid = 1'b0; ex_mem_bundle = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err, mem_wb_valid, mem_stall} !== '0)
            $display("FAIL reset_regs: got req=%b we=%b addr=%h wdata=%h err=%b wbv=%b stall=%b required all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err, mem_wb_valid, mem_stall);
        else n_pass++;
        n_checks++;
        if (mem_wb_bundle !== '0) $display("FAIL reset_bundle: got %h required 0", mem_wb_bundle);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        logic [74:0] b; logic [70:0] ob, eob; int lat, rq, st, elat, erq, est;
        logic we_s, held, es; logic [31:0] a_s, w_s;
        b = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 1'b0, $urandom, 5'd5);
        model(b, 0, 32'h0, elat, erq, est, eob, es);
        run_op(b, 0, 32'h0, lat, rq, st, ob, we_s, a_s, w_s, held);
        n_checks++;
        if (lat !== elat || st !== 0 || rq !== 0)
            $display("FAIL alu_timing: got lat=%0d stall=%0d req=%0d required lat=%0d stall=0 req=0", lat, st, rq, elat);
        else n_pass++;
        n_checks++;
        if (ob !== eob) $display("FAIL alu_bundle: got %h required %h", ob, eob);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (mem_wb_valid !== 1'b0) $display("FAIL alu_bubble: got wbv=%b required 0", mem_wb_valid);
        else n_pass++;
    endtask

    task automatic test_load();
        logic [74:0] b; logic [70:0] ob; int lat, rq, st;
        logic we_s, held; logic [31:0] a_s, w_s;
        b = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h1111_2222, 5'd9);
        run_op(b, 3, 32'hDEAD_BEEF, lat, rq, st, ob, we_s, a_s, w_s, held);
        n_checks++;
        if (rq !== 3 || st !== 3 || lat !== 4)
            $display("FAIL load_timing: got req=%0d stall=%0d lat=%0d required 3 3 4", rq, st, lat);
        else n_pass++;
        n_checks++;
        if (ob !== {1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 5'd9})
            $display("FAIL load_bundle: got %h required read_data=deadbeef", ob);
        else n_pass++;
        n_checks++;
        if (we_s !== 1'b0 || a_s !== 32'h100 || !held)
            $display("FAIL load_bus: got we=%b addr=%h held=%b required 0 100 1", we_s, a_s, held);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (mem_wb_valid !== 1'b0) $display("FAIL load_pulse: got wbv=%b required 0", mem_wb_valid);
        else n_pass++;
    endtask

    task automatic test_store();
        logic [74:0] b; logic [70:0] ob; int lat, rq, st;
        logic we_s, held; logic [31:0] a_s, w_s;
        b = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'hCAFE_F00D, 5'd3);
        run_op(b, 1, 32'h5555_5555, lat, rq, st, ob, we_s, a_s, w_s, held);
        n_checks++;
        if (we_s !== 1'b1 || a_s !== 32'h104 || w_s !== 32'hCAFE_F00D || !held)
            $display("FAIL store_bus: got we=%b addr=%h wdata=%h held=%b required 1 104 cafef00d 1",
                     we_s, a_s, w_s, held);
        else n_pass++;
        n_checks++;
        if (lat !== 2 || rq !== 1 || ob[68:37] !== 32'h0)
            $display("FAIL store_result: got lat=%0d req=%0d rdata=%h required 2 1 0", lat, rq, ob[68:37]);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [74:0] b; logic [70:0] ob; int lat, rq, st;
        logic we_s, held; logic [31:0] a_s, w_s;
        b = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 1'b0, 32'h0, 5'd7);
        run_op(b, 1, 32'h1234_5678, lat, rq, st, ob, we_s, a_s, w_s, held);
        err_m = 1'b1;
        n_checks++;
        if (rq !== 0 || st !== 0 || lat !== 1)
            $display("FAIL misaligned_timing: got req=%0d stall=%0d lat=%0d required 0 0 1", rq, st, lat);
        else n_pass++;
        n_checks++;
        if (ob !== {1'b0, 1'b1, 32'h0, 32'h0000_0102, 5'd7} || mem_err !== 1'b1)
            $display("FAIL misaligned_result: got bundle=%h err=%b required rw=0 err=1", ob, mem_err);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [74:0] b; logic [70:0] ob; int lat, rq, st;
        logic we_s, held; logic [31:0] a_s, w_s;
        do_reset();
        b = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 32'h0, 5'd12);
        run_op(b, 1000, 32'h0, lat, rq, st, ob, we_s, a_s, w_s, held);
        n_checks++;
        if (rq !== TO || lat !== TO + 1 || ob[70] !== 1'b0 || mem_err !== 1'b1)
            $display("FAIL timeout_abort: got req=%0d lat=%0d rw=%b err=%b required %0d %0d 0 1",
                     rq, lat, ob[70], mem_err, TO, TO + 1);
        else n_pass++;
        n_checks++;
        if (dmem_req !== 1'b0) $display("FAIL timeout_req_drop: got %b required 0", dmem_req);
        else n_pass++;
        do_reset();
        run_op(b, TO, 32'hA5A5_0F0F, lat, rq, st, ob, we_s, a_s, w_s, held);
        n_checks++;
        if (rq !== TO || lat !== TO + 1 || mem_err !== 1'b0 ||
            ob !== {1'b1, 1'b1, 32'hA5A5_0F0F, 32'h0000_0200, 5'd12})
            $display("FAIL ack_on_timeout: got req=%0d lat=%0d err=%b bundle=%h required normal completion",
                     rq, lat, mem_err, ob);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [74:0] b; logic [70:0] ob, eob; int lat, rq, st, elat, erq, est, k;
        logic we_s, held, es; logic [31:0] a_s, w_s, alu, rdv;
        for (int i = 0; i < 40; i++) begin
            alu = $urandom;
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            b   = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), alu, $urandom_range(0, 1),
                     $urandom, 5'($urandom_range(0, 31)));
            k   = $urandom_range(1, TO + 2);
            rdv = $urandom;
            model(b, k, rdv, elat, erq, est, eob, es);
            run_op(b, k, rdv, lat, rq, st, ob, we_s, a_s, w_s, held);
            err_m = err_m | es;
            n_checks++;
            if (lat !== elat || rq !== erq || st !== est || ob !== eob || mem_err !== err_m)
                $display("FAIL rand_op%0d: got lat=%0d req=%0d stall=%0d bundle=%h err=%b required %0d %0d %0d %h %b",
                         i, lat, rq, st, ob, mem_err, elat, erq, est, eob, err_m);
            else n_pass++;
            if (erq != 0) begin
                n_checks++;
                if (we_s !== b[70] || a_s !== alu || w_s !== b[36:5] || !held)
                    $display("FAIL rand_bus%0d: got we=%b addr=%h wdata=%h held=%b required %b %h %h 1",
                             i, we_s, a_s, w_s, held, b[70], alu, b[36:5]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ex_mem_valid  = 1'b1;
        ex_mem_bundle = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 1'b0, 32'h0, 5'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (dmem_req !== 1'b1) $display("FAIL midreset_pre: got req=%b required 1", dmem_req);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0 || mem_wb_valid !== 1'b0 || mem_stall !== 1'b0)
            $display("FAIL midreset_drop: got req=%b wbv=%b stall=%b required 0 0 0",
                     dmem_req, mem_wb_valid, mem_stall);
        else n_pass++;
        ex_mem_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; err_m = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        n_checks++;
        if (mem_wb_valid !== 1'b0 || dmem_req !== 1'b0 || mem_err !== 1'b0)
            $display("FAIL late_ack: got wbv=%b req=%b err=%b required 0 0 0", mem_wb_valid, dmem_req, mem_err);
        else n_pass++;
    endtask

    task automatic test_branch();
        logic v, br, z;
        for (int i = 0; i < 10; i++) begin
            v  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            br = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            z  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ex_mem_valid  = v;
            ex_mem_bundle = mk(1'b0, 1'b0, br, 1'b0, 1'b0, $urandom, z, $urandom, 5'd0);
            #1;
            n_checks++;
            if (branch_taken !== (v & br & z))
                $display("FAIL branch%0d: got %b required %b", i, branch_taken, v & br & z);
            else n_pass++;
            @(posedge clk); #1;
        end
        ex_mem_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_branch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
